clock_mode_fsm: RTL

CLOCK_MODE_FSM -- requirements
Module: clock_mode_fsm

---
 rtl/clock_mode_fsm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/clock_mode_fsm.sv
// Mode controller for a digital clock: init wait, normal run, time/alarm tuning and alarm ringing.
// All outputs are registered; keys are single-cycle debounced press pulses.
module clock_mode_fsm #(
    parameter int unsigned INIT_CYCLES  = 32'd50_000_000,
    parameter int unsigned IDLE_CYCLES  = 32'd500_000_000,
    parameter int unsigned ALARM_CYCLES = 32'd3_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic       alarm_en,
    input  logic       alarm_match,
    output logic [2:0] sys_status,
    output logic [1:0] tune_status,
    output logic       time_inc,
    output logic       alarm_inc,
    output logic       time_hold
);

    typedef enum logic [2:0] {
        StInit        = 3'd0,
        StNorm        = 3'd1,
        StTuneSel     = 3'd2,
        StTuning      = 3'd3,
        StTuneAlarm   = 3'd4,
        StAlarmTuning = 3'd5,
        StAlarming    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TNone   = 2'd0,
        TSecond = 2'd1,
        TMinute = 2'd2,
        THour   = 2'd3
    } field_e;

    state_e      state_q, state_d;
    field_e      field_q, field_d;
    logic [31:0] cnt_q, cnt_d;
    logic        match_q;
    logic        time_inc_q, time_inc_d;
    logic        alarm_inc_q, alarm_inc_d;
    logic        hold_q;

    logic do_mode, do_sel, do_inc, any_key;
    logic match_rise, idle_expired, in_tune;

    // Only the highest-priority key of a same-cycle group acts.
    assign do_mode = key_mode;
    assign do_sel  = key_sel & ~key_mode;
    assign do_inc  = key_inc & ~key_mode & ~key_sel;
    assign any_key = key_mode | key_sel | key_inc;

    assign match_rise   = alarm_match & ~match_q;
    assign idle_expired = (cnt_q == IDLE_CYCLES - 32'd1);
    assign in_tune      = state_q inside {StTuneSel, StTuning, StTuneAlarm, StAlarmTuning};

    function automatic field_e next_field(input field_e f);
        case (f)
            TSecond: next_field = TMinute;
            TMinute: next_field = THour;
            default: next_field = TSecond;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        time_inc_d  = 1'b0;
        alarm_inc_d = 1'b0;

        case (state_q)
            StInit: begin
                if (cnt_q == INIT_CYCLES - 32'd1) state_d = StNorm;
            end
            StNorm: begin
                // A fresh alarm match wins over any key press.
                if (alarm_en && match_rise) begin
                    state_d = StAlarming;
                end else if (do_mode) begin
                    state_d = StTuneSel;
                    field_d = TSecond;
                end
            end
            StTuneSel: begin
                if (do_mode) begin
                    state_d = StTuneAlarm;
                    field_d = TSecond;
                end else if (do_sel) begin
                    field_d = next_field(field_q);
                end else if (do_inc) begin
                    state_d = StTuning;
                end else if (idle_expired) begin
                    state_d = StNorm;
                end
            end
            StTuning: begin
                if (do_mode) begin
                    state_d = StNorm;
                end else if (do_sel) begin
                    state_d = StTuneSel;
                end else if (do_inc) begin
                    time_inc_d = 1'b1;
                end else if (idle_expired) begin
                    state_d = StNorm;
                end
            end
            StTuneAlarm: begin
                if (do_mode) begin
                    state_d = StNorm;
                end else if (do_sel) begin
                    field_d = next_field(field_q);
                end else if (do_inc) begin
                    state_d = StAlarmTuning;
                end else if (idle_expired) begin
                    state_d = StNorm;
                end
            end
            StAlarmTuning: begin
                if (do_mode) begin
                    state_d = StNorm;
                end else if (do_sel) begin
                    state_d = StTuneAlarm;
                end else if (do_inc) begin
                    alarm_inc_d = 1'b1;
                end else if (idle_expired) begin
                    state_d = StNorm;
                end
            end
            StAlarming: begin
                if (any_key || !alarm_en || (cnt_q == ALARM_CYCLES - 32'd1)) state_d = StNorm;
            end
            default: state_d = StNorm;
        endcase

        if (state_d inside {StInit, StNorm, StAlarming}) field_d = TNone;

        // Counter restarts on every state entry and, in tune states, on every key.
        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end else if (in_tune && any_key) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            field_q     <= TNone;
            cnt_q       <= 32'd0;
            match_q     <= 1'b0;
            time_inc_q  <= 1'b0;
            alarm_inc_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            cnt_q       <= cnt_d;
            match_q     <= alarm_match;
            time_inc_q  <= time_inc_d;
            alarm_inc_q <= alarm_inc_d;
            hold_q      <= (state_d == StTuning);
        end
    end

    assign sys_status  = state_q;
    assign tune_status = field_q;
    assign time_inc    = time_inc_q;
    assign alarm_inc   = alarm_inc_q;
    assign time_hold   = hold_q;

endmodule
